// File: rtl/pd_debug_cnt_pkg.sv
// Shared definitions for the PD debug counter bank: read address map,
// overflow flag bit positions and default widths.
package pd_debug_cnt_pkg;

  localparam int DEF_PACKET_SIZE_WIDTH = 12;
  localparam int DEF_CNT_WIDTH         = 32;
  localparam int DEF_BYTE_CNT_WIDTH    = 48;
  localparam int N_OVF                 = 6;

  typedef enum logic [2:0] {
    CNT_FIELD1   = 3'd0,
    CNT_FIELD2   = 3'd1,
    CNT_CAPTURE  = 3'd2,
    CNT_TOTAL    = 3'd3,
    CNT_F1_BYTES = 3'd4,
    CNT_F2_BYTES = 3'd5,
    CNT_SNAPSHOT = 3'd6,
    CNT_STATUS   = 3'd7
  } cnt_addr_e;

  // Overflow flags sit in the status word in read-address order.
  localparam int OVF_FIELD1   = 0;
  localparam int OVF_FIELD2   = 1;
  localparam int OVF_CAPTURE  = 2;
  localparam int OVF_TOTAL    = 3;
  localparam int OVF_F1_BYTES = 4;
  localparam int OVF_F2_BYTES = 5;

endpackage

// File: rtl/pd_debug_sat_counter.sv
// One counter/accumulator entry: adds a zero-extended amount, saturates or
// wraps on carry, and merges a same-cycle clearing read with an increment.
module pd_debug_sat_counter #(
  parameter int WIDTH     = 32,
  parameter int AMT_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc_en,
  input  logic [AMT_WIDTH-1:0] amount,
  input  logic                 sat,
  input  logic                 clr,
  input  logic                 rd_clr,
  output logic [WIDTH-1:0]     value,
  output logic                 ovf_pulse
);

  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] base;
  logic [WIDTH:0]   sum;

  always_comb begin
    // A clearing read restarts from zero, so a colliding increment survives.
    base      = rd_clr ? '0 : value_q;
    sum       = {1'b0, base} + {{(WIDTH + 1 - AMT_WIDTH){1'b0}}, amount};
    value_d   = base;
    ovf_pulse = 1'b0;
    if (clr) begin
      value_d = '0;
    end else if (inc_en) begin
      if (sum[WIDTH]) begin
        ovf_pulse = 1'b1;
        value_d   = sat ? '1 : sum[WIDTH-1:0];
      end else begin
        value_d = sum[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/pd_debug_cnt_bank.sv
// PD debug counter bank: event counters, byte accumulators, capture snapshot
// and sticky overflow flags behind a one-cycle read port.
// Optional macro PD_DEBUG_CNT_BANK_OVF_IRQ_EN adds cfg_ovf_irq_mask / ovf_irq.
module pd_debug_cnt_bank
  import pd_debug_cnt_pkg::*;
#(
  parameter int PACKET_SIZE_WIDTH = DEF_PACKET_SIZE_WIDTH,
  parameter int CNT_WIDTH         = DEF_CNT_WIDTH,
  parameter int BYTE_CNT_WIDTH    = DEF_BYTE_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dbg2cif_e_debug_pd_field1_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field2_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_capture_match_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_total_pd_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field1_byte_cnt_inc,
  input  logic                         dbg2cif_e_debug_pd_field2_byte_cnt_inc,
  input  logic [PACKET_SIZE_WIDTH-1:0] dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount,
  input  logic                         dbg2cif_e_debug_pd_capture_match_field1,
  input  logic [31:0]                  dbg2cif_c_debug_pd_out,
  input  logic                         cfg_clear_on_read,
  input  logic                         cfg_saturate,
  input  logic                         cfg_cnt_clear,
  input  logic                         rd_valid,
  input  logic [2:0]                   rd_addr,
  output logic                         rd_ack,
  output logic [BYTE_CNT_WIDTH-1:0]    rd_data
`ifdef PD_DEBUG_CNT_BANK_OVF_IRQ_EN
  ,
  input  logic [N_OVF-1:0]             cfg_ovf_irq_mask,
  output logic                         ovf_irq
`endif
);

  // Snapshot word needs 33 bits even if the accumulators are narrower.
  localparam int RD_W = (BYTE_CNT_WIDTH > 33) ? BYTE_CNT_WIDTH : 33;

  logic [3:0]                evt_inc;
  logic [1:0]                byte_inc;
  logic [7:0]                rd_clr_sel;
  logic [N_OVF-1:0]          ovf_pulse;
  logic [CNT_WIDTH-1:0]      evt_val  [4];
  logic [BYTE_CNT_WIDTH-1:0] byte_val [2];
  logic [RD_W-1:0]           rd_word;

  logic [31:0]               snapshot_q, snapshot_d;
  logic                      capture_valid_q, capture_valid_d;
  logic [N_OVF-1:0]          ovf_q, ovf_d;
  logic                      rd_ack_q, rd_ack_d;
  logic [BYTE_CNT_WIDTH-1:0] rd_data_q, rd_data_d;

  assign evt_inc  = {dbg2cif_e_debug_pd_total_pd_cnt_inc,
                     dbg2cif_e_debug_pd_capture_match_cnt_inc,
                     dbg2cif_e_debug_pd_field2_cnt_inc,
                     dbg2cif_e_debug_pd_field1_cnt_inc};
  assign byte_inc = {dbg2cif_e_debug_pd_field2_byte_cnt_inc,
                     dbg2cif_e_debug_pd_field1_byte_cnt_inc};

  always_comb begin
    rd_clr_sel = '0;
    if (rd_valid && cfg_clear_on_read) rd_clr_sel[rd_addr] = 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_evt
    pd_debug_sat_counter #(.WIDTH(CNT_WIDTH), .AMT_WIDTH(1)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc_en    (evt_inc[i]),
      .amount    (1'b1),
      .sat       (cfg_saturate),
      .clr       (cfg_cnt_clear),
      .rd_clr    (rd_clr_sel[i]),
      .value     (evt_val[i]),
      .ovf_pulse (ovf_pulse[OVF_FIELD1 + i])
    );
  end

  for (genvar j = 0; j < 2; j++) begin : g_byte
    pd_debug_sat_counter #(.WIDTH(BYTE_CNT_WIDTH), .AMT_WIDTH(PACKET_SIZE_WIDTH)) u_acc (
      .clk       (clk),
      .rst       (rst),
      .inc_en    (byte_inc[j]),
      .amount    (dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount),
      .sat       (cfg_saturate),
      .clr       (cfg_cnt_clear),
      .rd_clr    (rd_clr_sel[4 + j]),
      .value     (byte_val[j]),
      .ovf_pulse (ovf_pulse[OVF_F1_BYTES + j])
    );
  end

  always_comb begin
    rd_word = '0;
    case (cnt_addr_e'(rd_addr))
      CNT_FIELD1:   rd_word[CNT_WIDTH-1:0]      = evt_val[0];
      CNT_FIELD2:   rd_word[CNT_WIDTH-1:0]      = evt_val[1];
      CNT_CAPTURE:  rd_word[CNT_WIDTH-1:0]      = evt_val[2];
      CNT_TOTAL:    rd_word[CNT_WIDTH-1:0]      = evt_val[3];
      CNT_F1_BYTES: rd_word[BYTE_CNT_WIDTH-1:0] = byte_val[0];
      CNT_F2_BYTES: rd_word[BYTE_CNT_WIDTH-1:0] = byte_val[1];
      CNT_SNAPSHOT: begin
        rd_word[31:0] = snapshot_q;
        rd_word[32]   = capture_valid_q;
      end
      CNT_STATUS:   rd_word[N_OVF-1:0]          = ovf_q;
      default:      rd_word = '0;
    endcase
  end

  always_comb begin
    snapshot_d      = snapshot_q;
    capture_valid_d = capture_valid_q;
    // New overflows are ORed in after the clearing read so none is lost.
    ovf_d = (rd_clr_sel[CNT_STATUS] ? '0 : ovf_q) | ovf_pulse;
    if (dbg2cif_e_debug_pd_capture_match_field1) begin
      snapshot_d      = dbg2cif_c_debug_pd_out;
      capture_valid_d = 1'b1;
    end else if (rd_clr_sel[CNT_SNAPSHOT]) begin
      capture_valid_d = 1'b0;
    end
    if (cfg_cnt_clear) begin
      snapshot_d      = '0;
      capture_valid_d = 1'b0;
      ovf_d           = '0;
    end
    rd_ack_d  = rd_valid;
    rd_data_d = rd_valid ? rd_word[BYTE_CNT_WIDTH-1:0] : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot_q      <= '0;
      capture_valid_q <= 1'b0;
      ovf_q           <= '0;
      rd_ack_q        <= 1'b0;
      rd_data_q       <= '0;
    end else begin
      snapshot_q      <= snapshot_d;
      capture_valid_q <= capture_valid_d;
      ovf_q           <= ovf_d;
      rd_ack_q        <= rd_ack_d;
      rd_data_q       <= rd_data_d;
    end
  end

  // A reset landing while a response is pending suppresses that response.
  assign rd_ack  = rd_ack_q & ~rst;
  assign rd_data = rd_data_q;

`ifdef PD_DEBUG_CNT_BANK_OVF_IRQ_EN
  logic ovf_irq_q, ovf_irq_d;

  always_comb ovf_irq_d = |(ovf_q & cfg_ovf_irq_mask);

  always_ff @(posedge clk) begin
    if (rst) ovf_irq_q <= 1'b0;
    else     ovf_irq_q <= ovf_irq_d;
  end

  assign ovf_irq = ovf_irq_q;
`endif

endmodule

// File: tb/tb_pd_debug_cnt_bank.sv
// Scoreboard bench for pd_debug_cnt_bank: directed scenarios then random
// traffic, checked against an arithmetic model of the counter bank.
module tb_pd_debug_cnt_bank;

  localparam int PW = 12;
  localparam int CW = 8;
  localparam int BW = 48;
  localparam longint unsigned CMAX = (64'd1 << CW) - 64'd1;
  localparam longint unsigned BMAX = (64'd1 << BW) - 64'd1;

  logic          clk;
  logic          rst;
  logic          f1_inc, f2_inc, cap_inc, tot_inc, f1b_inc, f2b_inc;
  logic [PW-1:0] amount;
  logic          capture;
  logic [31:0]   pd_out;
  logic          cfg_clear_on_read, cfg_saturate, cfg_cnt_clear;
  logic          rd_valid;
  logic [2:0]    rd_addr;
  logic          rd_ack;
  logic [BW-1:0] rd_data;

  pd_debug_cnt_bank #(.PACKET_SIZE_WIDTH(PW), .CNT_WIDTH(CW), .BYTE_CNT_WIDTH(BW)) dut (
    .clk                                           (clk),
    .rst                                           (rst),
    .dbg2cif_e_debug_pd_field1_cnt_inc             (f1_inc),
    .dbg2cif_e_debug_pd_field2_cnt_inc             (f2_inc),
    .dbg2cif_e_debug_pd_capture_match_cnt_inc      (cap_inc),
    .dbg2cif_e_debug_pd_total_pd_cnt_inc           (tot_inc),
    .dbg2cif_e_debug_pd_field1_byte_cnt_inc        (f1b_inc),
    .dbg2cif_e_debug_pd_field2_byte_cnt_inc        (f2b_inc),
    .dbg2cif_eq_debug_pd_field_byte_cnt_inc_amount (amount),
    .dbg2cif_e_debug_pd_capture_match_field1       (capture),
    .dbg2cif_c_debug_pd_out                        (pd_out),
    .cfg_clear_on_read                             (cfg_clear_on_read),
    .cfg_saturate                                  (cfg_saturate),
    .cfg_cnt_clear                                 (cfg_cnt_clear),
    .rd_valid                                      (rd_valid),
    .rd_addr                                       (rd_addr),
    .rd_ack                                        (rd_ack),
    .rd_data                                       (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: entries 0..3 event counts, 4..5 byte totals.
  longint unsigned m_cnt [6];
  logic [31:0]     m_snap;
  bit              m_valid;
  bit [5:0]        m_ovf;

  logic [63:0] exp_q [$];
  logic [63:0] hold_exp;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_snap  = '0;
    m_valid = 0;
    m_ovf   = '0;
  endtask

  function automatic logic [63:0] model_read(input int a);
    logic [63:0] v;
    v = '0;
    if (a < 6)       v = m_cnt[a];
    else if (a == 6) v = {31'b0, m_valid, m_snap};
    else             v = {58'b0, m_ovf};
    return v;
  endfunction

  task automatic model_step();
    bit [5:0] inc;
    bit [5:0] new_ovf;
    bit crd;
    longint unsigned base, amt, lim;
    inc = {f2b_inc, f1b_inc, tot_inc, cap_inc, f2_inc, f1_inc};
    if (cfg_cnt_clear) begin
      model_reset();
    end else begin
      crd     = rd_valid && cfg_clear_on_read;
      new_ovf = '0;
      for (int i = 0; i < 6; i++) begin
        lim  = (i < 4) ? CMAX : BMAX;
        amt  = (i < 4) ? 1 : longint'(amount);
        base = (crd && int'(rd_addr) == i) ? 0 : m_cnt[i];
        if (inc[i] && base + amt > lim) begin
          new_ovf[i] = 1;
          m_cnt[i]   = cfg_saturate ? lim : base + amt - (lim + 1);
        end else if (inc[i]) begin
          m_cnt[i] = base + amt;
        end else begin
          m_cnt[i] = base;
        end
      end
      m_ovf = ((crd && rd_addr == 3'd7) ? 6'b0 : m_ovf) | new_ovf;
      if (capture) begin
        m_snap  = pd_out;
        m_valid = 1;
      end else if (crd && rd_addr == 3'd6) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic idle();
    f1_inc = 0; f2_inc = 0; cap_inc = 0; tot_inc = 0; f1b_inc = 0; f2b_inc = 0;
    capture = 0; cfg_cnt_clear = 0; rd_valid = 0; rd_addr = '0;
  endtask

  // Inputs for this cycle are already driven; log the expected response,
  // advance the model, then move past the edge.
  task automatic step();
    if (rd_valid) exp_q.push_back(model_read(int'(rd_addr)));
    model_step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int a);
    rd_valid = 1;
    rd_addr  = 3'(a);
    step();
  endtask

  // Monitor: pops an expectation for every ack, otherwise rd_data must hold.
  always @(negedge clk) begin
    if (rst) begin
      hold_exp = '0;
    end else if (rd_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ack: got ack with rd_data 0x%0h, expected no ack", rd_data);
      end else begin
        hold_exp = exp_q.pop_front();
        chk("rd_data", 64'(rd_data), hold_exp);
      end
    end else begin
      chk("rd_hold", 64'(rd_data), hold_exp);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1;
    idle();
    cfg_clear_on_read = 0;
    cfg_saturate = 0;
    amount = '0;
    pd_out = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 64'(rd_ack), 64'd0);
    chk("reset_data", 64'(rd_data), 64'd0);
    rst = 0;
    for (int a = 0; a < 8; a++) rd(a);

    // Five field1 pulses.
    repeat (5) begin f1_inc = 1; step(); end
    rd(0);

    // Total counter wrap, then saturate.
    cfg_saturate = 0;
    repeat (256) begin tot_inc = 1; step(); end
    rd(3);
    rd(7);
    cfg_saturate = 1;
    repeat (256) begin tot_inc = 1; step(); end
    rd(3);
    rd(7);
    cfg_saturate = 0;

    // Clearing read colliding with an increment.
    cfg_clear_on_read = 1;
    repeat (7) begin f2_inc = 1; step(); end
    f2_inc = 1; rd(1);
    rd(1);
    rd(1);
    rd(7);
    rd(7);
    cfg_clear_on_read = 0;

    // Byte accumulation.
    amount = 12'hFFF;
    repeat (3) begin f1b_inc = 1; step(); end
    rd(4);
    rd(5);

    // Snapshot capture and collision with a clearing read.
    pd_out = 32'hDEADBEEF; capture = 1; step();
    rd(6);
    cfg_clear_on_read = 1;
    pd_out = 32'h12345678; capture = 1; rd(6);
    cfg_clear_on_read = 0;
    rd(6);
    cfg_clear_on_read = 1;
    rd(6);
    rd(6);
    cfg_clear_on_read = 0;

    // Clear-all with every pulse active and a same-cycle read.
    repeat (3) begin f1_inc = 1; f2b_inc = 1; cap_inc = 1; step(); end
    f1_inc = 1; f2_inc = 1; cap_inc = 1; tot_inc = 1; f1b_inc = 1; f2b_inc = 1;
    capture = 1; pd_out = 32'hCAFEF00D; cfg_cnt_clear = 1; rd_addr = 3'd0; rd(0);
    for (int a = 0; a < 8; a++) rd(a);

    // Reset the cycle after a read request: no ack appears.
    repeat (4) begin f1_inc = 1; step(); end
    rd_valid = 1; rd_addr = 3'd0;
    model_step();
    @(posedge clk);
    #1;
    idle();
    rst = 1;
    @(negedge clk);
    chk("rst_mid_read_ack", 64'(rd_ack), 64'd0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    rd(0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) cfg_clear_on_read = 1'($urandom_range(0, 1));
      if (c % 500 == 0) cfg_saturate = 1'($urandom_range(0, 1));
      f1_inc  = 1'($urandom_range(0, 1));
      f2_inc  = 1'($urandom_range(0, 1));
      cap_inc = 1'($urandom_range(0, 1));
      tot_inc = ($urandom_range(0, 3) != 0);
      f1b_inc = 1'($urandom_range(0, 1));
      f2b_inc = 1'($urandom_range(0, 1));
      amount  = PW'($urandom);
      capture = ($urandom_range(0, 3) == 0);
      pd_out  = $urandom;
      cfg_cnt_clear = ($urandom_range(0, 255) == 0);
      rd_valid = 1'($urandom_range(0, 1));
      rd_addr  = 3'($urandom_range(0, 7));
      step();
    end
    cfg_clear_on_read = 0;
    for (int a = 0; a < 8; a++) rd(a);
    repeat (3) step();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
